jstk2_frame_scheduler: RTL
==========================

Name: jstk2_frame_scheduler

Overview:
- Sequences 5-byte SPI frames to the PmodJSTK2 through a byte-level SPI master; owns chip-select and inter-byte timing.
- Arbitrates two requesters: color updates (the 24-bit {R,G,B} color word) and a periodic position poll.
- Decodes the returned position and button bytes. Sits between the color-select logic and the SPI byte engine.

Parameters:
- POLL_DIV, 120000: clk cycles between poll requests (100 Hz at 12 MHz).
- SS_SETUP, 180: cycles from ss_n low to the first byte_start.
- BYTE_GAP, 300: cycles from byte_done to the next byte_start. Also used as the ss_n-high hold after a frame.
- TIMEOUT, 4095: maximum cycles to wait for byte_done before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- color_in  in  24  {R[23:16],G[15:8],B[7:0]} requested LED color
- color_valid  in  1  one-cycle pulse; latch color_in as pending
- byte_start  out  1  one-cycle pulse to SPI master; byte_tx valid this cycle
- byte_tx  out  8  byte to transmit
- byte_rx  in  8  received byte, valid when byte_done=1
- byte_done  in  1  one-cycle pulse from SPI master, byte complete
- ss_n  out  1  JSTK2 chip select, active low
- x_pos  out  10  last decoded X
- y_pos  out  10  last decoded Y
- buttons  out  2  {trigger, stick} from last frame
- pos_valid  out  1  one-cycle pulse when x_pos/y_pos/buttons update
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset (async, rst_n=0) values:
  - Outputs: ss_n=1; byte_start=0; byte_tx=0; x_pos=0; y_pos=0; buttons=0; pos_valid=0; busy=0; timeout_err=0.
  - Internal: color_pending=0, poll_pending=0, poll counter=0, color register=24'h000000, state=IDLE.
  - Reset mid-frame forces these values immediately. No frame completes and pos_valid does not pulse.
- Poll counter:
  - Free-running 0..POLL_DIV-1. Sets poll_pending on wrap.
  - Keeps counting during frames. A second wrap while poll_pending is already set is absorbed; requests do not accumulate.
- Color capture:
  - color_valid=1 latches color_in and sets color_pending. Latest value wins; earlier pending values are overwritten.
- States:
  - IDLE -> SETUP when color_pending or poll_pending.
    - Frame type is decided at this transition. A color frame has cmd 0x84 and payload R,G,B,0x00. A poll frame has cmd 0x00 and payload 0x00 x4.
    - Color has priority. Either frame type clears both pendings.
    - The color payload is snapshotted into a 4-byte frame buffer.
    - If color_valid arrives in the same cycle, the set wins over the clear: the new value is latched, color_pending stays 1, and another color frame follows.
  - SETUP: ss_n=0; wait SS_SETUP cycles -> SEND.
  - SEND: byte_start=1 for exactly 1 cycle with byte_tx=frame[idx] -> WAIT.
  - WAIT: wait for byte_done and store byte_rx into rx[idx].
    - If idx<4: -> GAP.
    - If idx==4: -> HOLD, assert ss_n=1, and decode in the same edge.
    - If TIMEOUT cycles pass without byte_done: ss_n=1, timeout_err pulses, -> HOLD. rx bytes are discarded and pos_valid does not pulse.
  - GAP: wait BYTE_GAP cycles, idx++, -> SEND.
  - HOLD: ss_n=1; wait BYTE_GAP cycles -> IDLE.
- Decode, registered on the edge that consumes the 5th byte_done; pos_valid pulses the next cycle:
  - x_pos = {rx1[1:0], rx0}
  - y_pos = {rx3[1:0], rx2}
  - buttons = rx4[1:0]
- Latency: first byte_start at SS_SETUP+1 cycles after leaving IDLE.
- byte_done received outside WAIT is ignored.
- Counters are sized by $clog2 of the largest parameter.
- idx is 3 bits and wraps to 0 on entering SETUP.

Decomposition:
- Shared package jstk2_pkg:
  - CMD_SET_LED=8'h84, CMD_NOP=8'h00, FRAME_LEN=5.
  - State enum {IDLE, SETUP, SEND, WAIT, GAP, HOLD}.
  - Byte-index field positions for X/Y/button decode.
- One sub-module, jstk2_delay_timer: loadable down-counter with load, count value and expired output. It is reused for SETUP, GAP, HOLD and TIMEOUT.

Test Plan:
- Parameters for all scenarios: POLL_DIV=1000, SS_SETUP=4, BYTE_GAP=6, TIMEOUT=50. A behavioural SPI master returns byte_done 8 cycles after byte_start.
- Idle poll: no color_valid.
  - First ss_n fall after 1000 cycles.
  - byte_tx = 00,00,00,00,00.
  - rx 0x34,0x02,0x10,0x03,0x01 -> x_pos=0x234, y_pos=0x310, buttons=2'b01, pos_valid 1 cycle.
- Color frame: color_valid with 24'h7F0000 in IDLE.
  - byte_tx = 84,7F,00,00,00.
  - A poll wrap mid-frame produces exactly one poll frame afterwards.
- Overwrite/collision cases:
  - Two color_valid pulses (7F0000 then 007F00) before frame start -> one frame, payload 00,7F,00.
  - color_valid in the frame-start cycle -> a second color frame follows.
- Timing: measure ss_n-low to first byte_start = 4 cycles, byte_done to next byte_start = 6 cycles, last byte_done to ss_n=1 = 1 cycle, ss_n high ≥6 cycles before the next frame.
- Timeout: the master drops the 3rd byte_done.
  - 50 cycles later: timeout_err pulse, ss_n=1, no pos_valid, x_pos unchanged.
  - Next poll completes normally.
- Reset mid-frame: assert rst_n=0 during byte 2.
  - All outputs at reset values asynchronously.
  - After release: no pos_valid until a full new frame completes.

Source files
------------

// File: rtl/jstk2_pkg.sv
// jstk2_pkg -- shared constants, state encoding and decode field positions for the JSTK2 scheduler.
// Rev 1.0
`default_nettype none

package jstk2_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'h84;
  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam int         FRAME_LEN   = 5;

  // Received-byte positions used to rebuild the position and button fields
  localparam int X_LO_IDX = 0;
  localparam int X_HI_IDX = 1;
  localparam int Y_LO_IDX = 2;
  localparam int Y_HI_IDX = 3;
  localparam int BTN_IDX  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4,
    HOLD  = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jstk2_delay_timer.sv
// jstk2_delay_timer -- loadable down-counter that parks at zero; expired while the count is zero.
// Rev 1.0
`default_nettype none

module jstk2_delay_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count   = r_count;
  assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/jstk2_frame_scheduler.sv
// jstk2_frame_scheduler -- arbitrates color/poll requests into 5-byte JSTK2 SPI frames and decodes position.
// Rev 1.0
`default_nettype none

module jstk2_frame_scheduler
  import jstk2_pkg::*;
#(
  parameter int POLL_DIV = 120000,
  parameter int SS_SETUP = 180,
  parameter int BYTE_GAP = 300,
  parameter int TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] color_in,
  input  logic        color_valid,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic [7:0]  byte_rx,
  input  logic        byte_done,
  output logic        ss_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  buttons,
  output logic        pos_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int MAXV = max2(max2(POLL_DIV, SS_SETUP), max2(BYTE_GAP, TIMEOUT));
  localparam int CW   = $clog2(MAXV);

  state_t        r_state, w_next;
  logic [2:0]    r_idx;
  logic [7:0]    r_frame [FRAME_LEN];
  logic [7:0]    r_rx    [FRAME_LEN-1];
  logic [23:0]   r_color;
  logic          r_color_pending, r_poll_pending;
  logic [CW-1:0] r_poll_cnt;
  logic [9:0]    r_x_pos, r_y_pos;
  logic [1:0]    r_buttons;
  logic          r_pos_valid, r_timeout_err;

  logic          w_poll_wrap, w_start, w_advance, w_store, w_decode, w_abort;
  logic          w_tmr_load, w_tmr_expired;
  logic [CW-1:0] w_tmr_val, w_tmr_count;

  jstk2_delay_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_val),
    .o_count   (w_tmr_count),
    .o_expired (w_tmr_expired)
  );

  assign w_poll_wrap = (r_poll_cnt == CW'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Timer reloads are one less than the wanted residency because the
  // counter spends a cycle at zero before the state moves on.
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_start    = 1'b0;
    w_advance  = 1'b0;
    w_store    = 1'b0;
    w_decode   = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      IDLE: if (r_color_pending || r_poll_pending) begin
        w_next     = SETUP;
        w_start    = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(SS_SETUP - 1);
      end
      SETUP: if (w_tmr_expired) w_next = SEND;
      SEND: begin
        w_next     = WAIT;
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(TIMEOUT - 1);
      end
      WAIT: if (byte_done) begin
        w_store    = 1'b1;
        w_tmr_load = 1'b1;
        if (r_idx == 3'(FRAME_LEN - 1)) begin
          w_decode  = 1'b1;
          w_next    = HOLD;
          w_tmr_val = CW'(BYTE_GAP - 1);
        end else begin
          w_next    = GAP;
          w_tmr_val = CW'(BYTE_GAP - 2);
        end
      end else if (w_tmr_count == '0) begin
        w_abort    = 1'b1;
        w_next     = HOLD;
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(BYTE_GAP - 1);
      end
      GAP: if (w_tmr_expired) begin
        w_next    = SEND;
        w_advance = 1'b1;
      end
      HOLD: if (w_tmr_expired) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt      <= '0;
      r_poll_pending  <= 1'b0;
      r_color         <= '0;
      r_color_pending <= 1'b0;
      r_idx           <= '0;
      r_x_pos         <= '0;
      r_y_pos         <= '0;
      r_buttons       <= '0;
      r_pos_valid     <= 1'b0;
      r_timeout_err   <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++)     r_frame[i] <= '0;
      for (int i = 0; i < FRAME_LEN - 1; i++) r_rx[i]    <= '0;
    end else begin
      r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + CW'(1);
      // New requests arriving on the frame-start edge survive the clear
      if (w_poll_wrap)  r_poll_pending <= 1'b1;
      else if (w_start) r_poll_pending <= 1'b0;
      if (color_valid) begin
        r_color         <= color_in;
        r_color_pending <= 1'b1;
      end else if (w_start) begin
        r_color_pending <= 1'b0;
      end
      if (w_start) begin
        r_idx      <= '0;
        r_frame[0] <= r_color_pending ? CMD_SET_LED : CMD_NOP;
        r_frame[1] <= r_color_pending ? r_color[23:16] : 8'h00;
        r_frame[2] <= r_color_pending ? r_color[15:8]  : 8'h00;
        r_frame[3] <= r_color_pending ? r_color[7:0]   : 8'h00;
        r_frame[4] <= 8'h00;
      end else if (w_advance) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_store && !w_decode) r_rx[r_idx[1:0]] <= byte_rx;
      if (w_decode) begin
        r_x_pos   <= {r_rx[X_HI_IDX][1:0], r_rx[X_LO_IDX]};
        r_y_pos   <= {r_rx[Y_HI_IDX][1:0], r_rx[Y_LO_IDX]};
        r_buttons <= byte_rx[1:0];
      end
      r_pos_valid   <= w_decode;
      r_timeout_err <= w_abort;
    end
  end

  assign byte_start  = (r_state == SEND);
  assign byte_tx     = (r_state == SEND) ? r_frame[r_idx] : 8'h00;
  assign ss_n        = !((r_state == SETUP) || (r_state == SEND) ||
                         (r_state == WAIT)  || (r_state == GAP));
  assign busy        = (r_state != IDLE);
  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign buttons     = r_buttons;
  assign pos_valid   = r_pos_valid;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
